// File: rtl/serial_tx_buffer_pkg.sv
// Shared types for the serial transmit path: sequencer state encoding and byte width.
package serial_tx_buffer_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    TXB_IDLE,
    TXB_LAUNCH,
    TXB_WAIT_BUSY,
    TXB_WAIT_DONE
  } TxBufState_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with registered count/full, sticky overflow and synchronous flush.
module byte_fifo
  import serial_tx_buffer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              pop_ok, accept, drop;

  // A pop frees a slot in the same clk, so a full FIFO still takes a push then.
  assign pop_ok  = pop && (count != '0);
  assign accept  = push && !flush && (!full || pop_ok);
  assign drop    = push && !flush && !accept;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (flush) count_nxt = '0;
    else begin
      case ({accept, pop_ok})
        2'b10:   count_nxt = count + ONE;
        2'b01:   count_nxt = count - ONE;
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
        if (drop)   overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_tx_buffer.sv
// Byte FIFO plus start_tx/tx_ready transmit sequencer feeding the RS232 TX block.
module serial_tx_buffer
  import serial_tx_buffer_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_push,
  output logic              in_full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  input  logic              flush,
  output logic [BYTE_W-1:0] tx_data,
  output logic              start_tx,
  input  logic              tx_ready,
  output logic              overflow,
  output logic              ack_lost
);

  localparam int             TMR_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  TxBufState_t       state, state_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic              pop, ack_set;
  logic [BYTE_W-1:0] head;

  byte_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (in_push),
    .wr_data  (in_data),
    .pop      (pop),
    .rd_data  (head),
    .count    (count),
    .full     (in_full),
    .overflow (overflow)
  );

  assign pop      = (state == TXB_IDLE) && (count != '0) && tx_ready;
  assign start_tx = (state == TXB_LAUNCH);
  assign empty    = (count == '0) && (state == TXB_IDLE);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    ack_set   = 1'b0;
    case (state)
      TXB_IDLE:      if (pop) state_nxt = TXB_LAUNCH;
      TXB_LAUNCH: begin
        state_nxt = TXB_WAIT_BUSY;
        timer_nxt = '0;
      end
      TXB_WAIT_BUSY: begin
        // Timer counts clks spent here; the last one without tx_ready falling is a lost ack.
        if (!tx_ready) state_nxt = TXB_WAIT_DONE;
        else if (timer == TMO_LAST) begin
          ack_set   = 1'b1;
          state_nxt = TXB_IDLE;
        end else timer_nxt = timer + TMR_ONE;
      end
      TXB_WAIT_DONE: if (tx_ready) state_nxt = TXB_IDLE;
      default:       state_nxt = TXB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= TXB_IDLE;
      timer    <= '0;
      tx_data  <= '0;
      ack_lost <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (pop) tx_data <= head;
      // A timeout landing in a flush clk is a fresh event and survives the clear.
      if (ack_set)    ack_lost <= 1'b1;
      else if (flush) ack_lost <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_tx_buffer.sv
// Self-checking bench: directed vector table, corner sequences and randomized traffic vs a queue model.
module tb_serial_tx_buffer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_push;
  logic       in_full;
  logic       empty;
  logic [4:0] count;
  logic       flush;
  logic [7:0] tx_data;
  logic       start_tx;
  logic       tx_ready;
  logic       overflow;
  logic       ack_lost;

  serial_tx_buffer #(.DEPTH(DEPTH), .ADDR_W(4), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_push(in_push), .in_full(in_full),
    .empty(empty), .count(count), .flush(flush), .tx_data(tx_data), .start_tx(start_tx),
    .tx_ready(tx_ready), .overflow(overflow), .ack_lost(ack_lost)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] q[$];
  logic [7:0] last_tx;
  logic       exp_ovf, exp_ack, prev_start, rs_auto, rs_fast;
  int         busy, n_sent, max_cnt;

  typedef struct {
    logic       push;
    logic [7:0] data;
    logic       rdy;
    logic       exp_start;
    logic [7:0] exp_txd;
    int         exp_cnt;
    logic       exp_empty;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_tx    = 8'h00;
    exp_ovf    = 1'b0;
    exp_ack    = 1'b0;
    prev_start = 1'b0;
  endtask

  // One clock: apply current inputs, then update the queue model from what the edge did.
  task automatic step();
    logic       p, f;
    logic [7:0] d;
    p = in_push; d = in_data; f = flush;
    @(posedge clk); #1;
    if (start_tx) begin
      chk("no_back_to_back_start", int'(prev_start), 0);
      if (q.size() == 0) chk("start_with_nothing_queued", 1, 0);
      else begin
        last_tx = q.pop_front();
        n_sent++;
      end
    end
    chk("tx_data", tx_data, last_tx);
    if (f) begin
      q.delete();
      exp_ovf = 1'b0;
      exp_ack = 1'b0;
    end else if (p) begin
      if (q.size() < DEPTH) q.push_back(d);
      else exp_ovf = 1'b1;
    end
    chk("count", count, q.size());
    chk("in_full", in_full, int'(q.size() == DEPTH));
    chk("overflow", overflow, exp_ovf);
    chk("ack_lost", ack_lost, exp_ack);
    if (count > max_cnt) max_cnt = count;
    prev_start = start_tx;
    if (rs_auto) begin
      if (start_tx) begin
        tx_ready = 1'b0;
        busy = rs_fast ? 1 : $urandom_range(1, 3);
      end else if (!tx_ready) begin
        if (busy > 0) busy--;
        else tx_ready = 1'b1;
      end
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    in_push = 1'b0;
    flush   = 1'b0;
    rs_auto = 1'b1;
    while ((q.size() != 0 || !empty) && n < 3000) begin
      step();
      n++;
    end
    chk(name, int'(q.size() == 0 && empty), 1);
  endtask

  task automatic wait_start(input string name, input int maxc);
    logic got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (start_tx) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, got, 1);
  endtask

  task automatic do_flush();
    in_push = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    int sent0, starts;
    rst = 1'b0; in_push = 1'b0; in_data = 8'h00; flush = 1'b0; tx_ready = 1'b1;
    rs_auto = 1'b0; rs_fast = 1'b0; busy = 0; n_sent = 0; max_cnt = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_full", in_full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_start_tx", start_tx, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ack_lost", ack_lost, 0);
    rst = 1'b1;

    // Single byte A5, then RS232 busy for 10 clks.
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 0, 1'b0};
    for (int i = 2; i < 12; i++) tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 0, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 0, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 0, 1'b1};
    for (int i = 0; i < 14; i++) begin
      in_push = tbl[i].push; in_data = tbl[i].data; tx_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_start_tx", i), start_tx, tbl[i].exp_start);
      chk($sformatf("vec%0d_tx_data", i), tx_data, tbl[i].exp_txd);
      chk($sformatf("vec%0d_count", i), count, tbl[i].exp_cnt);
      chk($sformatf("vec%0d_empty", i), empty, tbl[i].exp_empty);
    end
    in_push = 1'b0;

    // Fill to 16 with RS232 busy, overflow on the 17th, then drain in order.
    tx_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      in_push = 1'b1; in_data = 8'(i);
      step();
    end
    chk("fill_in_full", in_full, 1);
    chk("fill_count", count, 16);
    in_data = 8'h11;
    step();
    chk("overflow_set", overflow, 1);
    chk("overflow_count", count, 16);
    sent0 = n_sent;
    busy = 0;
    drain("drain_full");
    chk("drain_full_sent", n_sent - sent0, 16);
    chk("overflow_sticky", overflow, 1);

    // Full FIFO with a pop in the same clk still accepts the push.
    do_flush();
    rs_auto = 1'b0; tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_push = 1'b1; in_data = 8'h20 + 8'(i);
      step();
    end
    rs_auto = 1'b1; busy = 0; tx_ready = 1'b1;
    in_data = 8'h77;
    step();
    chk("full_pop_start", start_tx, 1);
    chk("full_pop_count", count, 16);
    chk("full_pop_overflow", overflow, 0);
    drain("drain_full_pop");

    // tx_ready never falls: lost ack after 4 clks in WAIT_BUSY, next byte still goes out.
    do_flush();
    rs_auto = 1'b0; tx_ready = 1'b1;
    in_push = 1'b1; in_data = 8'h5A;
    step();
    in_push = 1'b0;
    wait_start("ack_first_start", 8);
    step();
    for (int i = 0; i < 3; i++) step();
    chk("ack_not_yet", ack_lost, 0);
    exp_ack = 1'b1;
    step();
    chk("ack_lost_set", ack_lost, 1);
    chk("ack_back_idle", empty, 1);
    in_push = 1'b1; in_data = 8'hC3;
    rs_auto = 1'b1; busy = 0;
    step();
    in_push = 1'b0;
    wait_start("ack_next_start", 8);
    chk("ack_next_data", tx_data, 8'hC3);
    drain("drain_ack");

    // Flush during WAIT_DONE with 5 queued bytes.
    do_flush();
    rs_auto = 1'b0; tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_push = 1'b1; in_data = 8'h40 + 8'(i);
      step();
    end
    in_push = 1'b0; tx_ready = 1'b1;
    step();
    chk("fl_launch", start_tx, 1);
    tx_ready = 1'b0;
    step(); step();
    chk("fl_queued", count, 5);
    do_flush();
    chk("fl_count0", count, 0);
    step();
    tx_ready = 1'b1;
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (start_tx) starts++;
    end
    chk("fl_no_more_start", starts, 0);
    chk("fl_empty", empty, 1);
    chk("fl_tx_data_held", tx_data, 8'h40);

    // Wrap-around: 40 bytes, one per 3 clks, fast RS232.
    rs_auto = 1'b1; rs_fast = 1'b1; busy = 0; tx_ready = 1'b1;
    sent0 = n_sent; max_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      in_push = 1'b1; in_data = 8'($urandom);
      step();
      in_push = 1'b0;
      step(); step();
    end
    drain("drain_wrap");
    chk("wrap_sent", n_sent - sent0, 40);
    chk("wrap_max_count", int'(max_cnt <= DEPTH), 1);
    rs_fast = 1'b0;

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 800; i++) begin
      in_push = ($urandom_range(0, 1) == 1);
      in_data = 8'($urandom);
      flush   = ($urandom_range(0, 63) == 0);
      step();
    end
    drain("drain_random");

    // Async reset while in LAUNCH.
    rs_auto = 1'b0; tx_ready = 1'b1;
    in_push = 1'b1; in_data = 8'hE7;
    step();
    in_push = 1'b0;
    wait_start("rst_launch_start", 8);
    rst = 1'b0;
    #1;
    chk("rst_mid_start_tx", start_tx, 0);
    chk("rst_mid_tx_data", tx_data, 0);
    chk("rst_mid_empty", empty, 1);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_in_full", in_full, 0);
    chk("rst_mid_overflow", overflow, 0);
    chk("rst_mid_ack_lost", ack_lost, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    chk("post_rst_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
